// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai31_stim.sv
// Stimulus sequencer and response checker for an oai31 cell: walks all 16 input vectors and scores ZN.
// Optional OAI31_STIM_ARC_EN adds 14 conditional B->ZN arc checks after the static walk.
module gf180mcu_fd_sc_mcu9t5v0__oai31_stim #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ZN,
    output logic             A1,
    output logic             A2,
    output logic             A3,
    output logic             B,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [3:0]       FAIL_VEC
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_HOLD,
        S_CHECK,
        S_FINISH
    } state_t;

`ifdef OAI31_STIM_ARC_EN
    localparam logic [4:0] LAST_IDX = 5'd29;
`else
    localparam logic [4:0] LAST_IDX = 5'd15;
`endif
    localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic [3:0]       hold_q, hold_d;
    logic [3:0]       stim_q, stim_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [3:0]       fail_q, fail_d;

    // Check index 0..15 is the static vector itself; 16..29 walk A conditions 1..7 with B=0 then B=1.
    function automatic logic [3:0] vec_of(input logic [4:0] idx);
`ifdef OAI31_STIM_ARC_EN
        logic [4:0] a;
        if (idx < 5'd16) begin
            return idx[3:0];
        end
        a = idx - 5'd16;
        return {a[3:1] + 3'd1, a[0]};
`else
        return idx[3:0];
`endif
    endfunction

    function automatic logic oai31(input logic [3:0] v);
        return !((v[3] | v[2] | v[1]) & v[0]);
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        stim_d  = stim_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_APPLY;
                    idx_d   = 5'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fail_d  = 4'hF;
                end
            end
            S_APPLY: begin
                stim_d  = vec_of(idx_q);
                hold_d  = 4'(SETTLE_CYCLES);
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (hold_q <= 4'd1) begin
                    state_d = S_CHECK;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            S_CHECK: begin
                // Case inequality so an undriven or unknown ZN is scored as a failure.
                if (ZN !== oai31(stim_q)) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + CNT_W'(1);
                    end
                    if (err_q == '0) begin
                        fail_d = stim_q;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = S_APPLY;
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_q == '0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            idx_q   <= 5'd0;
            hold_q  <= 4'd0;
            stim_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= 4'hF;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign A1       = stim_q[3];
    assign A2       = stim_q[2];
    assign A3       = stim_q[1];
    assign B        = stim_q[0];
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign PASS     = pass_q;
    assign ERR_CNT  = err_q;
    assign FAIL_VEC = fail_q;

endmodule
